// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/EXEC/MEM/WB control FSM for the 8-bit CPU, with a BUSYWAIT timeout watchdog.
// Optional feature: define SHIFT_OPS_EN to decode opcodes 0C-0F as shift/rotate ALU ops.
module multicycle_control_unit #(
    parameter int OPCODE_W    = 8,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                instr_valid,
    input  logic                busywait,
    output logic                writeenable,
    output logic [ALUOP_W-1:0]  aluop,
    output logic                alusrc,
    output logic                nemux,
    output logic                jump,
    output logic                branch,
    output logic                memread,
    output logic                memwrite,
    output logic                mem_to_reg,
    output logic                pc_update,
    output logic                illegal
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {FETCH, EXEC, MEM, WB} state_t;

    state_t           state, stateNext;
    logic [7:0]       opReg;
    logic             opBad;
    logic [CNT_W-1:0] memCount;
    logic             timeoutHit;

    logic       decWe, decSrc, decNeg, decJump, decBranch, decLoad, decStore, decIllegal;
    logic [2:0] decAlu;
    logic [2:0] aluop3;

    // Any set bit above the decoded byte makes the whole opcode illegal.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            opReg    <= '0;
            opBad    <= 1'b0;
            memCount <= '0;
        end else begin
            state <= stateNext;
            if (state == FETCH && instr_valid) begin
                opReg <= opcode[7:0];
                opBad <= ((opcode >> 8) != '0);
            end
            if (state == MEM && stateNext == MEM)
                memCount <= memCount + CNT_W'(1);
            else
                memCount <= '0;
        end
    end

    assign timeoutHit = (MEM_TIMEOUT != 0) && (memCount == CNT_W'(MEM_TIMEOUT));

    always_comb begin
        decWe      = 1'b0;
        decSrc     = 1'b0;
        decNeg     = 1'b0;
        decJump    = 1'b0;
        decBranch  = 1'b0;
        decLoad    = 1'b0;
        decStore   = 1'b0;
        decIllegal = 1'b0;
        decAlu     = 3'b000;
        if (opBad) begin
            decIllegal = 1'b1;
        end else begin
            case (opReg)
                8'h00: begin decWe = 1'b1; decSrc = 1'b1; decAlu = 3'b001; end
                8'h01: begin decWe = 1'b1; decSrc = 1'b1; decAlu = 3'b001; decNeg = 1'b1; end
                8'h02: begin decWe = 1'b1; decSrc = 1'b1; decAlu = 3'b010; end
                8'h03: begin decWe = 1'b1; decSrc = 1'b1; decAlu = 3'b011; end
                8'h04: begin decWe = 1'b1; decSrc = 1'b1; end
                8'h05: decWe = 1'b1;
                8'h06: decJump = 1'b1;
                8'h07: begin decBranch = 1'b1; decAlu = 3'b001; decNeg = 1'b1; decSrc = 1'b1; end
                8'h08: begin decLoad = 1'b1; decSrc = 1'b1; end
                8'h09: decLoad = 1'b1;
                8'h0A: begin decStore = 1'b1; decSrc = 1'b1; end
                8'h0B: decStore = 1'b1;
`ifdef SHIFT_OPS_EN
                8'h0C: begin decWe = 1'b1; decAlu = 3'b100; end
                8'h0D: begin decWe = 1'b1; decAlu = 3'b101; end
                8'h0E: begin decWe = 1'b1; decAlu = 3'b110; end
                8'h0F: begin decWe = 1'b1; decAlu = 3'b111; end
`endif
                default: decIllegal = 1'b1;
            endcase
        end
    end

    // Outputs follow state and the latched opcode; only the MEM exit also looks at busywait.
    always_comb begin
        stateNext   = state;
        writeenable = 1'b0;
        aluop3      = 3'b000;
        alusrc      = 1'b0;
        nemux       = 1'b0;
        jump        = 1'b0;
        branch      = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        mem_to_reg  = 1'b0;
        pc_update   = 1'b0;
        illegal     = 1'b0;
        case (state)
            FETCH: begin
                if (instr_valid)
                    stateNext = EXEC;
            end
            EXEC: begin
                if (decIllegal) begin
                    illegal   = 1'b1;
                    pc_update = 1'b1;
                    stateNext = FETCH;
                end else if (decLoad || decStore) begin
                    aluop3    = decAlu;
                    alusrc    = decSrc;
                    stateNext = MEM;
                end else begin
                    writeenable = decWe;
                    aluop3      = decAlu;
                    alusrc      = decSrc;
                    nemux       = decNeg;
                    jump        = decJump;
                    branch      = decBranch;
                    pc_update   = 1'b1;
                    stateNext   = FETCH;
                end
            end
            MEM: begin
                aluop3 = decAlu;
                alusrc = decSrc;
                if (timeoutHit) begin
                    illegal   = 1'b1;
                    pc_update = 1'b1;
                    stateNext = FETCH;
                end else begin
                    memread  = decLoad;
                    memwrite = decStore;
                    if (!busywait) begin
                        if (decLoad) begin
                            stateNext = WB;
                        end else begin
                            pc_update = 1'b1;
                            stateNext = FETCH;
                        end
                    end
                end
            end
            WB: begin
                writeenable = 1'b1;
                mem_to_reg  = 1'b1;
                pc_update   = 1'b1;
                stateNext   = FETCH;
            end
            default: stateNext = FETCH;
        endcase
    end

    assign aluop = ALUOP_W'(aluop3);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle expected output words are queued
// as stimulus is driven and compared mid-cycle on the falling edge.
module tb_multicycle_control_unit;

    localparam int OPW = 10;
    localparam int AW  = 4;
    localparam int TMO = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           instrValid = 1'b0;
    logic           busywait = 1'b0;
    logic [OPW-1:0] opcode = '0;
    logic           writeenable, alusrc, nemux, jump, branch;
    logic           memread, memwrite, mem_to_reg, pc_update, illegal;
    logic [AW-1:0]  aluop;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [13:0] v;
    } exp_t;

    exp_t expQ[$];

    multicycle_control_unit #(
        .OPCODE_W(OPW), .ALUOP_W(AW), .MEM_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .instr_valid(instrValid),
        .busywait(busywait), .writeenable(writeenable), .aluop(aluop), .alusrc(alusrc),
        .nemux(nemux), .jump(jump), .branch(branch), .memread(memread),
        .memwrite(memwrite), .mem_to_reg(mem_to_reg), .pc_update(pc_update),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] pk(input logic we, input logic [3:0] alu, input logic src,
                                       input logic neg, input logic j, input logic b,
                                       input logic mr, input logic mw, input logic m2r,
                                       input logic pcu, input logic ill);
        return {we, alu, src, neg, j, b, mr, mw, m2r, pcu, ill};
    endfunction

    localparam logic [13:0] ZERO = 14'h0;

    function automatic logic [13:0] execExp(input logic [7:0] op);
        case (op)
            8'h00: return pk(1, 4'd1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
            8'h01: return pk(1, 4'd1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
            8'h02: return pk(1, 4'd2, 1, 0, 0, 0, 0, 0, 0, 1, 0);
            8'h03: return pk(1, 4'd3, 1, 0, 0, 0, 0, 0, 0, 1, 0);
            8'h04: return pk(1, 4'd0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
            8'h05: return pk(1, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            8'h06: return pk(0, 4'd0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
            8'h07: return pk(0, 4'd1, 1, 1, 0, 1, 0, 0, 0, 1, 0);
            8'h08: return pk(0, 4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            8'h09: return pk(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            8'h0A: return pk(0, 4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            8'h0B: return pk(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef SHIFT_OPS_EN
            8'h0C: return pk(1, 4'd4, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            8'h0D: return pk(1, 4'd5, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            8'h0E: return pk(1, 4'd6, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            8'h0F: return pk(1, 4'd7, 0, 0, 0, 0, 0, 0, 0, 1, 0);
`endif
            default: return pk(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [OPW-1:0] op,
                                 input logic b, input string tag, input logic [13:0] e);
        exp_t item;
        @(posedge clk);
        #1;
        reset      = r;
        instrValid = v;
        opcode     = op;
        busywait   = b;
        item.tag   = tag;
        item.v     = e;
        expQ.push_back(item);
    endtask

    // One instruction: FETCH, EXEC, then MEM stall cycles, timeout or completion, and WB for loads.
    task automatic runInstr(input logic [OPW-1:0] op, input int stalls, input logic hold,
                            input logic [OPW-1:0] junk, input logic tmo);
        logic [7:0]  low;
        logic        bad, isLoad, isStore, src;
        logic [13:0] memv;
        low     = op[7:0];
        bad     = ((op >> 8) != '0);
        isLoad  = !bad && (low == 8'h08 || low == 8'h09);
        isStore = !bad && (low == 8'h0A || low == 8'h0B);
        src     = (low == 8'h08 || low == 8'h0A);
        applyStimulus(0, 1, op, 0, "fetch", ZERO);
        applyStimulus(0, hold, junk, 0, "exec", bad ? pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1) : execExp(low));
        if (isLoad || isStore) begin
            memv = pk(0, 0, src, 0, 0, 0, isLoad, isStore, 0, 0, 0);
            for (int i = 0; i < stalls; i++)
                applyStimulus(0, 0, junk, 1, "memstall", memv);
            if (tmo)
                applyStimulus(0, 0, junk, 1, "timeout", pk(0, 0, src, 0, 0, 0, 0, 0, 0, 1, 1));
            else if (isStore)
                applyStimulus(0, 0, junk, 0, "storedone", pk(0, 0, src, 0, 0, 0, 0, 1, 0, 1, 0));
            else begin
                applyStimulus(0, 0, junk, 0, "loaddone", memv);
                applyStimulus(0, 0, junk, 0, "wb", pk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput(e.tag, {writeenable, aluop, alusrc, nemux, jump, branch,
                                memread, memwrite, mem_to_reg, pc_update, illegal}, e.v);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1, 0, '0, 0, "reset", ZERO);
        applyStimulus(1, 0, '0, 0, "reset", ZERO);
        applyStimulus(0, 0, 10'h001, 0, "idle", ZERO);

        for (int op = 0; op < 8; op++)
            runInstr(OPW'(op), 0, 1'b0, 10'h03F, 1'b0);

        runInstr(10'h03F, 0, 1'b0, '0, 1'b0);
        runInstr(10'h00D, 0, 1'b0, '0, 1'b0);
        runInstr(10'h00C, 0, 1'b0, '0, 1'b0);
        runInstr(10'h100, 0, 1'b0, '0, 1'b0);

        runInstr(10'h009, 0, 1'b0, '0, 1'b0);
        runInstr(10'h00A, 0, 1'b0, '0, 1'b0);
        runInstr(10'h008, 3, 1'b0, '0, 1'b0);
        runInstr(10'h00B, 2, 1'b0, '0, 1'b0);
        runInstr(10'h00B, TMO, 1'b0, '0, 1'b1);
        applyStimulus(0, 0, '0, 1, "posttimeout", ZERO);

        // Reset mid-stall, then a store whose stall count would hit a stale counter.
        applyStimulus(0, 1, 10'h008, 0, "fetch", ZERO);
        applyStimulus(0, 0, '0, 1, "exec", execExp(8'h08));
        applyStimulus(0, 0, '0, 1, "memstall", pk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        applyStimulus(0, 0, '0, 1, "memstall", pk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        applyStimulus(1, 0, '0, 1, "rstmem", pk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        applyStimulus(1, 0, '0, 1, "rstheld", ZERO);
        applyStimulus(0, 0, '0, 1, "postrst", ZERO);
        runInstr(10'h00B, 3, 1'b0, '0, 1'b0);

        runInstr(10'h000, 0, 1'b1, 10'h007, 1'b0);
        runInstr(10'h007, 0, 1'b1, 10'h006, 1'b0);
        runInstr(10'h006, 0, 1'b0, '0, 1'b0);

        applyStimulus(0, 0, '0, 0, "idle", ZERO);
        @(negedge clk);
        @(negedge clk);
        checkOutput("qempty", 14'(expQ.size()), ZERO);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
